if_stage_queue: RTL and testbench

//  Parametrised successor to the single-entry IF/ID stage register: a DEPTH-entry

---
 rtl/if_stage_queue.sv | 58 +++++
 tb/tb_if_stage_queue.sv | 126 ++++++++++++
 2 files changed

// File: rtl/if_stage_queue.sv
// if_stage_queue: DEPTH-entry {pc, instruction} FIFO between fetch and decode, with freeze and flush; IF_QUEUE_OCC_EN adds occupancy output
module if_stage_queue #(
  parameter int BIT_NUMBER = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIT_NUMBER-1:0] pc_in,
  input  logic [BIT_NUMBER-1:0] instruction_in,
  output logic                  out_valid,
  output logic [BIT_NUMBER-1:0] pc,
  output logic [BIT_NUMBER-1:0] instruction
`ifdef IF_QUEUE_OCC_EN
  ,
  output logic [PTR_W:0]        occupancy
`endif
);
  localparam logic [PTR_W:0] full_count = (PTR_W+1)'(DEPTH);
  logic [2*BIT_NUMBER-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count;
  logic push, pop;
  logic [2*BIT_NUMBER-1:0] head;
  assign in_ready = count != full_count;
  assign out_valid = count != '0;
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & ~freeze & ~flush;
  assign head = mem[rd_ptr];
  assign pc = out_valid ? head[2*BIT_NUMBER-1:BIT_NUMBER] : '0;
  assign instruction = out_valid ? head[BIT_NUMBER-1:0] : '0;
`ifdef IF_QUEUE_OCC_EN
  assign occupancy = count;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {pc_in, instruction_in};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
    end
  end
endmodule

// File: tb/tb_if_stage_queue.sv
// tb_if_stage_queue: directed self-checking bench for if_stage_queue
module tb_if_stage_queue;
  logic clk = 0, rst = 1, flush = 0, freeze = 0, in_valid = 0;
  logic in_ready, out_valid;
  logic [31:0] pc_in = 0, instruction_in = 0, pc, instruction;
  int errors = 0, checks = 0;
`ifdef IF_QUEUE_OCC_EN
  logic [2:0] occupancy;
`endif
  if_stage_queue #(.BIT_NUMBER(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in),
    .instruction_in(instruction_in), .out_valid(out_valid), .pc(pc),
    .instruction(instruction)
`ifdef IF_QUEUE_OCC_EN
    , .occupancy(occupancy)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] exp_pc [5];
    exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    #12 rst = 0;
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_instr", instruction, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef IF_QUEUE_OCC_EN
    check("rst_occ", occupancy, 0);
`endif
    in_valid = 1; pc_in = 32'h4; instruction_in = 32'hE3A01005;
    step();
    in_valid = 0;
    check("t2_out_valid", out_valid, 1);
    check("t2_pc", pc, 32'h4);
    check("t2_instr", instruction, 32'hE3A01005);
    step();
    check("t2_empty", out_valid, 0);
    check("t2_pc_zero", pc, 0);
    freeze = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; pc_in = 32'h4 + 32'(4*i); instruction_in = 32'h100 + 32'(i);
      check($sformatf("t3_in_ready%0d", i), in_ready, i < 4 ? 1 : 0);
      step();
    end
    check("t3_head_pc", pc, 32'h4);
    check("t3_head_instr", instruction, 32'h100);
    check("t3_full", in_ready, 0);
`ifdef IF_QUEUE_OCC_EN
    check("t3_occ", occupancy, 4);
`endif
    freeze = 0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_pc%0d", k), pc, exp_pc[k]);
      check($sformatf("t4_valid%0d", k), out_valid, 1);
      if (k == 0) check("t4_ready_full", in_ready, 0);
      if (k == 1) check("t4_ready_free", in_ready, 1);
      step();
      if (k == 1) in_valid = 0;
    end
    check("t4_empty", out_valid, 0);
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; pc_in = 32'h30 + 32'(4*i); instruction_in = 32'h200 + 32'(i);
      step();
    end
    check("t5_pre_head", pc, 32'h30);
    flush = 1; pc_in = 32'h20; instruction_in = 32'h220;
    step();
    flush = 0; in_valid = 0;
    check("t5_flush_valid", out_valid, 0);
    check("t5_flush_pc", pc, 0);
    check("t5_flush_ready", in_ready, 1);
`ifdef IF_QUEUE_OCC_EN
    check("t5_occ", occupancy, 0);
`endif
    in_valid = 1; pc_in = 32'h40; instruction_in = 32'h240;
    step();
    in_valid = 0;
    check("t5_new_head", pc, 32'h40);
    check("t5_new_instr", instruction, 32'h240);
    freeze = 0;
    step();
    check("t5_drained", out_valid, 0);
    freeze = 1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; pc_in = 32'h100 + 32'(4*i); instruction_in = 32'h300 + 32'(i);
      step();
    end
    freeze = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; pc_in = 32'h108 + 32'(4*i); instruction_in = 32'h302 + 32'(i);
      check($sformatf("t6_pc%0d", i), pc, 32'h100 + 32'(4*i));
      check($sformatf("t6_instr%0d", i), instruction, 32'h300 + 32'(i));
      check($sformatf("t6_ready%0d", i), in_ready, 1);
`ifdef IF_QUEUE_OCC_EN
      check($sformatf("t6_occ%0d", i), occupancy, 2);
`endif
      step();
    end
    in_valid = 0; freeze = 1;
    check("t6_tail_pc", pc, 32'h128);
    check("t6_tail_valid", out_valid, 1);
    #2 rst = 1;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_pc", pc, 0);
    check("t6_async_instr", instruction, 0);
    check("t6_async_ready", in_ready, 1);
    #3 rst = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
